vc_input_requester: RTL and testbench

Per-input-port virtual-channel buffer and request generator for the virtual channel router; it is the requesting end of the request/grant interface served by `arbiter_round_robin`. It stores incoming flits in one FIFO per VC. It raises a request for every VC that has a buffered flit and a downstream credit. On a grant it dequeues that VC's head flit onto the crossbar input, consumes one downstream credit and returns one credit upstream.

---
 rtl/vc_router_pkg.sv | 12 +
 rtl/vc_input_requester_if.sv | 32 +++
 rtl/vc_fifo.sv | 55 +++++
 rtl/vc_input_requester.sv | 109 ++++++++++
 tb/tb_vc_input_requester.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_router_pkg.sv
// Shared types and default sizing for the virtual-channel router.
// Sizing constants only; no logic lives here.
package vc_router_pkg;
  localparam int NUM_VCS    = 4;
  localparam int DEPTH      = 4;
  localparam int CREDITS    = 4;
  localparam int FLIT_WIDTH = 32;
  localparam int VC_W       = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

  typedef logic [FLIT_WIDTH-1:0] flit_t;
  typedef logic [VC_W-1:0]       vc_id_t;
endpackage

// File: rtl/vc_input_requester_if.sv
// Link, request/grant and credit signals of one router input port.
// master = the requester itself, slave = its environment (upstream, arbiter, downstream).
interface vc_input_requester_if #(
  parameter int NUM_VCS    = vc_router_pkg::NUM_VCS,
  parameter int FLIT_WIDTH = vc_router_pkg::FLIT_WIDTH
);
  localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

  logic                  in_valid;
  logic [VW-1:0]         in_vc;
  logic [FLIT_WIDTH-1:0] in_flit;
  logic [NUM_VCS-1:0]    requests;
  logic [NUM_VCS-1:0]    grants;
  logic                  out_valid;
  logic [VW-1:0]         out_vc;
  logic [FLIT_WIDTH-1:0] out_flit;
  logic                  credit_in_valid;
  logic [VW-1:0]         credit_in_vc;
  logic                  credit_out_valid;
  logic [VW-1:0]         credit_out_vc;
  logic                  err;

  modport master (
    input  in_valid, in_vc, in_flit, grants, credit_in_valid, credit_in_vc,
    output requests, out_valid, out_vc, out_flit, credit_out_valid, credit_out_vc, err
  );

  modport slave (
    output in_valid, in_vc, in_flit, grants, credit_in_valid, credit_in_vc,
    input  requests, out_valid, out_vc, out_flit, credit_out_valid, credit_out_vc, err
  );
endinterface

// File: rtl/vc_fifo.sv
// Single-VC circular flit buffer; written flit visible at head next cycle.
// No internal backpressure: caller must not push when full nor pop when empty.
module vc_fifo #(
  parameter int DEPTH      = vc_router_pkg::DEPTH,
  parameter int FLIT_WIDTH = vc_router_pkg::FLIT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [FLIT_WIDTH-1:0] dat_i,
  output logic [FLIT_WIDTH-1:0] head_o,
  output logic                  empty_o,
  output logic                  full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0]         cnt_q, cnt_d;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_d  = push_i ? next_ptr(wr_q) : wr_q;
    rd_d  = pop_i  ? next_ptr(rd_q) : rd_q;
    cnt_d = cnt_q;
    if (push_i && !pop_i)      cnt_d = cnt_q + OW'(1);
    else if (!push_i && pop_i) cnt_d = cnt_q - OW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= dat_i;
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == OW'(DEPTH));
endmodule

// File: rtl/vc_input_requester.sv
// Per-input-port VC buffers + request generator; granted head leaves combinationally, pops at the edge.
// Requests need a buffered flit and a downstream credit; upstream is credit-limited, overflow is dropped and flagged.
module vc_input_requester #(
  parameter int NUM_VCS    = vc_router_pkg::NUM_VCS,
  parameter int DEPTH      = vc_router_pkg::DEPTH,
  parameter int FLIT_WIDTH = vc_router_pkg::FLIT_WIDTH,
  parameter int CREDITS    = vc_router_pkg::CREDITS
) (
  input  logic                 clk,
  input  logic                 reset,
  vc_input_requester_if.master bus
);
  localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  logic [NUM_VCS-1:0]    push, pop, empty, full, req;
  logic [FLIT_WIDTH-1:0] head [NUM_VCS];
  logic [CW-1:0]         cred_q [NUM_VCS];
  logic [CW-1:0]         cred_d [NUM_VCS];
  logic                  err_q, err_d;
  logic                  cr_vld_q, cr_vld_d;
  logic [VW-1:0]         cr_vc_q, cr_vc_d;
  logic                  gnt_onehot, accept, reject;
  logic [VW-1:0]         gnt_idx;
  logic                  full_err, sat_err;

  genvar g;
  generate
    for (g = 0; g < NUM_VCS; g++) begin : g_vc
      vc_fifo #(.DEPTH(DEPTH), .FLIT_WIDTH(FLIT_WIDTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push[g]),
        .pop_i   (pop[g]),
        .dat_i   (bus.in_flit),
        .head_o  (head[g]),
        .empty_o (empty[g]),
        .full_o  (full[g])
      );
    end
  endgenerate

  // Registered state only, so grants can never loop back into requests.
  always_comb begin
    req = '0;
    for (int v = 0; v < NUM_VCS; v++) req[v] = !empty[v] && (cred_q[v] != '0);
  end

  always_comb begin
    gnt_onehot = (bus.grants != '0) && ((bus.grants & (bus.grants - NUM_VCS'(1))) == '0);
    accept     = gnt_onehot && ((bus.grants & ~req) == '0);
    reject     = (bus.grants != '0) && !accept;
    gnt_idx    = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (bus.grants[v]) gnt_idx = VW'(v);
    end
    pop = accept ? bus.grants : '0;
  end

  always_comb begin
    push     = '0;
    full_err = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (bus.in_valid && (bus.in_vc == VW'(v))) begin
        push[v]  = !full[v];
        full_err = full_err | full[v];
      end
    end
  end

  // Credit-in and consume on the same VC cancel out, which also avoids a false saturation.
  always_comb begin
    sat_err = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      cred_d[v] = cred_q[v];
      if (bus.credit_in_valid && (bus.credit_in_vc == VW'(v)) && !pop[v]) begin
        if (cred_q[v] == CW'(CREDITS)) sat_err = 1'b1;
        else                           cred_d[v] = cred_q[v] + CW'(1);
      end else if (pop[v] && !(bus.credit_in_valid && (bus.credit_in_vc == VW'(v)))) begin
        cred_d[v] = cred_q[v] - CW'(1);
      end
    end
    err_d    = err_q | full_err | reject | sat_err;
    cr_vld_d = accept;
    cr_vc_d  = accept ? gnt_idx : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VCS; v++) cred_q[v] <= CW'(CREDITS);
      err_q    <= 1'b0;
      cr_vld_q <= 1'b0;
      cr_vc_q  <= '0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) cred_q[v] <= cred_d[v];
      err_q    <= err_d;
      cr_vld_q <= cr_vld_d;
      cr_vc_q  <= cr_vc_d;
    end
  end

  assign bus.requests         = req;
  assign bus.out_valid        = accept;
  assign bus.out_vc           = accept ? gnt_idx : '0;
  assign bus.out_flit         = accept ? head[gnt_idx] : '0;
  assign bus.credit_out_valid = cr_vld_q;
  assign bus.credit_out_vc    = cr_vc_q;
  assign bus.err              = err_q;
endmodule

// File: tb/tb_vc_input_requester.sv
// Directed + randomized bench for vc_input_requester against a queue/credit reference model.
module tb_vc_input_requester;
  import vc_router_pkg::*;

  localparam int NV = 4;
  localparam int D  = 4;
  localparam int FW = 32;
  localparam int CR = 4;
  localparam int VW = $clog2(NV);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vc_input_requester_if #(.NUM_VCS(NV), .FLIT_WIDTH(FW)) bus ();

  vc_input_requester #(.NUM_VCS(NV), .DEPTH(D), .FLIT_WIDTH(FW), .CREDITS(CR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: per-VC flit queues, credit counts, sticky error, registered credit return.
  flit_t mq [NV][$];
  int    cred [NV];
  bit    m_err;
  bit    m_cvld;
  int    m_cvc;
  int    n_vec = 0;
  int    n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NV-1:0] m_req();
    logic [NV-1:0] r;
    r = '0;
    for (int v = 0; v < NV; v++) r[v] = (mq[v].size() > 0) && (cred[v] > 0);
    return r;
  endfunction

  function automatic bit m_accept(input logic [NV-1:0] gr, input logic [NV-1:0] r);
    return (gr != '0) && ($countones(gr) == 1) && ((gr & ~r) == '0);
  endfunction

  function automatic int idx_of(input logic [NV-1:0] gr);
    for (int v = 0; v < NV; v++) if (gr[v]) return v;
    return 0;
  endfunction

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      cred[v] = CR;
    end
    m_err  = 1'b0;
    m_cvld = 1'b0;
    m_cvc  = 0;
  endtask

  task automatic idle();
    bus.in_valid        = 1'b0;
    bus.in_vc           = '0;
    bus.in_flit         = '0;
    bus.grants          = '0;
    bus.credit_in_valid = 1'b0;
    bus.credit_in_vc    = '0;
  endtask

  task automatic wr(input int vc, input logic [FW-1:0] dat);
    bus.in_valid = 1'b1;
    bus.in_vc    = VW'(vc);
    bus.in_flit  = dat;
  endtask

  // Called just after a rising edge; samples mid-cycle.
  task automatic check_cycle();
    logic [NV-1:0] r;
    bit acc;
    int gi;
    #2;
    r   = m_req();
    acc = m_accept(bus.grants, r);
    chk("requests", 64'(bus.requests), 64'(r));
    chk("out_valid", 64'(bus.out_valid), 64'(acc));
    if (acc) begin
      gi = idx_of(bus.grants);
      chk("out_vc", 64'(bus.out_vc), 64'(gi));
      chk("out_flit", 64'(bus.out_flit), 64'(mq[gi][0]));
    end
    chk("credit_out_valid", 64'(bus.credit_out_valid), 64'(m_cvld));
    if (m_cvld) chk("credit_out_vc", 64'(bus.credit_out_vc), 64'(m_cvc));
    chk("err", 64'(bus.err), 64'(m_err));
  endtask

  task automatic advance();
    logic [NV-1:0] r;
    bit acc, was_full;
    int gi, iv, cv;
    r   = m_req();
    acc = m_accept(bus.grants, r);
    gi  = idx_of(bus.grants);
    iv  = int'(bus.in_vc);
    cv  = int'(bus.credit_in_vc);
    was_full = (mq[iv].size() >= D);
    if (bus.grants != '0 && !acc) m_err = 1'b1;
    if (acc) void'(mq[gi].pop_front());
    if (bus.in_valid) begin
      if (was_full) m_err = 1'b1;
      else          mq[iv].push_back(bus.in_flit);
    end
    if (bus.credit_in_valid) begin
      if (cred[cv] == CR && !(acc && gi == cv)) m_err = 1'b1;
      else                                      cred[cv]++;
    end
    if (acc) cred[gi]--;
    m_cvld = acc;
    m_cvc  = acc ? gi : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    check_cycle();
    advance();
  endtask

  // Reset asserted mid-cycle with a grant pending: outputs must drop at once.
  task automatic do_reset();
    bus.grants = '1;
    reset = 1'b0;
    #1;
    chk("rst_requests", 64'(bus.requests), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_vc", 64'(bus.out_vc), 64'(0));
    chk("rst_out_flit", 64'(bus.out_flit), 64'(0));
    chk("rst_credit_out_valid", 64'(bus.credit_out_valid), 64'(0));
    chk("rst_credit_out_vc", 64'(bus.credit_out_vc), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
  endtask

  int n_deq;
  int rr;
  int vsel;
  logic [NV-1:0] rq, gsel;

  initial begin
    idle();
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Basic dequeue on VC2
    wr(2, 32'hA0); cyc(); idle();
    chk("basic_req", 64'(bus.requests), 64'b0100);
    bus.grants = 4'b0100;
    check_cycle();
    chk("basic_out_vc", 64'(bus.out_vc), 64'd2);
    chk("basic_out_flit", 64'(bus.out_flit), 64'hA0);
    advance(); idle();
    chk("basic_cout_valid", 64'(bus.credit_out_valid), 64'd1);
    chk("basic_cout_vc", 64'(bus.credit_out_vc), 64'd2);
    chk("basic_req_after", 64'(bus.requests), 64'd0);
    cyc();

    // Credit exhaustion on VC0
    do_reset();
    for (int i = 0; i < 4; i++) begin wr(0, 32'h100 + i); cyc(); end
    idle();
    n_deq = 0;
    for (int i = 0; i < 7; i++) begin
      bus.grants = m_req() & 4'b0001;
      if (i == 1) wr(0, 32'h104); else bus.in_valid = 1'b0;
      check_cycle();
      if (bus.out_valid) n_deq++;
      advance();
    end
    idle();
    chk("exhaust_deq_count", 64'(n_deq), 64'd4);
    chk("exhaust_req0", 64'(bus.requests[0]), 64'd0);
    bus.credit_in_valid = 1'b1; bus.credit_in_vc = '0;
    cyc(); idle();
    chk("credit_wake_req0", 64'(bus.requests[0]), 64'd1);
    bus.grants = 4'b0001;
    check_cycle();
    chk("credit_wake_flit", 64'(bus.out_flit), 64'h104);
    advance(); idle(); cyc();

    // Overflow, in-order drain and pointer wrap on VC1, credits returned as consumed
    do_reset();
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 0; i < ((rnd == 0) ? D + 1 : D); i++) begin
        wr(1, 32'(rnd * 16 + i)); cyc();
      end
      idle();
      if (rnd == 0) chk("overflow_err", 64'(bus.err), 64'd1);
      for (int i = 0; i < D + 1; i++) begin
        bus.grants = m_req() & 4'b0010;
        bus.credit_in_valid = bus.grants[1];
        bus.credit_in_vc = 2'd1;
        cyc();
      end
      idle();
      chk("wrap_empty", 64'(bus.requests), 64'd0);
    end

    // Simultaneous push/pop on VC3, then credit-in with consume
    do_reset();
    wr(3, 32'h31); cyc();
    wr(3, 32'h32); bus.grants = 4'b1000;
    check_cycle();
    chk("simul_old_head", 64'(bus.out_flit), 64'h31);
    advance(); idle();
    chk("simul_occupancy", 64'(bus.requests[3]), 64'd1);
    bus.grants = 4'b1000; bus.credit_in_valid = 1'b1; bus.credit_in_vc = 2'd3;
    check_cycle();
    chk("simul_new_head", 64'(bus.out_flit), 64'h32);
    advance(); idle();
    chk("simul_err_clear", 64'(bus.err), 64'd0);
    for (int i = 0; i < 4; i++) begin wr(3, 32'h40 + i); cyc(); end
    idle();
    n_deq = 0;
    for (int i = 0; i < 6; i++) begin
      bus.grants = m_req() & 4'b1000;
      check_cycle();
      if (bus.out_valid) n_deq++;
      advance();
    end
    idle();
    chk("credit_cancel_count", 64'(n_deq), 64'd3);

    // Illegal grants
    do_reset();
    wr(0, 32'h50); cyc(); wr(1, 32'h51); cyc(); idle();
    bus.grants = 4'b0011;
    check_cycle();
    chk("illegal_multi_ov", 64'(bus.out_valid), 64'd0);
    advance(); idle();
    chk("illegal_multi_err", 64'(bus.err), 64'd1);
    chk("illegal_multi_nopop", 64'(bus.requests), 64'b0011);
    do_reset();
    wr(0, 32'h60); cyc(); idle();
    bus.grants = 4'b0100;
    check_cycle();
    chk("illegal_empty_ov", 64'(bus.out_valid), 64'd0);
    advance(); idle();
    chk("illegal_empty_err", 64'(bus.err), 64'd1);
    chk("illegal_empty_nopop", 64'(bus.requests), 64'b0001);

    // Randomized legal traffic with a round-robin grant source and a reset mid-stream
    do_reset();
    rr = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) do_reset();
      rq = m_req();
      gsel = '0;
      if (rq != '0 && ($urandom % 8) != 0) begin
        for (int k = 0; k < NV; k++) begin
          vsel = (rr + k) % NV;
          if (rq[vsel] && gsel == '0) begin
            gsel[vsel] = 1'b1;
            rr = vsel + 1;
          end
        end
      end
      bus.grants = gsel;
      vsel = $urandom % NV;
      bus.in_valid = ($urandom % 4 != 0) && (mq[vsel].size() < D);
      bus.in_vc    = VW'(vsel);
      bus.in_flit  = $urandom;
      vsel = $urandom % NV;
      bus.credit_in_valid = ($urandom % 3 == 0) && (cred[vsel] < CR);
      bus.credit_in_vc    = VW'(vsel);
      cyc();
    end
    idle();
    chk("legal_no_err", 64'(bus.err), 64'd0);

    // Unconstrained traffic, including illegal grants and excess credits
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rq = m_req();
      bus.grants          = ($urandom % 2 == 0) ? (rq & NV'(1 << ($urandom % NV))) : NV'($urandom);
      bus.in_valid        = ($urandom % 2 == 0);
      bus.in_vc           = VW'($urandom);
      bus.in_flit         = $urandom;
      bus.credit_in_valid = ($urandom % 4 == 0);
      bus.credit_in_vc    = VW'($urandom);
      cyc();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
